op_issue_queue: RTL and testbench
=================================

Name: op_issue_queue

Overview:
- Upstream feeder for multi_op_processor.
- Buffers {opcode, data} commands arriving on a valid/ready interface and presents them one at a time on the processor's op_sel/data_in.
- Captures the processor's combinational data_out and returns it in order, tagged with a sequence index, on a valid/ready result interface.
- Lets benches and upstream logic stream commands with backpressure, without manually pacing the processor.

Parameters:
- DEPTH, 8: command FIFO entries (power of two, >=2).
- IDX_W, 16: width of the sequence index attached to each command/result.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of queue, result slot and index counter.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid & in_ready at clk edge.
- in_opcode  in  2  operation (ADD/SUB/MUL/DIV encoding of the processor).
- in_data  in  8  operand.
- proc_op_sel  out  2  drives processor op_sel.
- proc_data_in  out  8  drives processor data_in.
- proc_data_out  in  8  processor result (combinational from proc_* outputs).
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid & res_ready at clk edge.
- res_data  out  8  captured proc_data_out.
- res_opcode  out  2  opcode that produced res_data.
- res_index  out  IDX_W  sequence index of that command.
- count  out  $clog2(DEPTH+1)  FIFO occupancy (excludes the command in issue/result slot).

Behaviour:
- Reset is asynchronous and active-high (rst): all outputs 0 except in_ready=1. State IDLE, FIFO empty, index counter 0.
- Accept:
  - in_ready = !fifo_full; independent of res_ready.
  - Each accepted command is stored with index = counter; the counter then increments, wrapping modulo 2^IDX_W.
- Issue FSM:
  - IDLE: if FIFO non-empty, pop head into registered proc_op_sel/proc_data_in, latch opcode/index, go to DRIVE.
  - DRIVE (exactly 1 cycle): at the next edge, capture proc_data_out into res_data, assert res_valid, go to HOLD.
  - HOLD: hold res_* stable while res_valid & !res_ready.
    - On handshake with FIFO non-empty: pop next into proc_* and go to DRIVE; res_valid deasserts for that cycle.
    - On handshake with FIFO empty: res_valid=0, go to IDLE.
- Latency and throughput:
  - A command accepted into an empty idle block at edge E0 is popped at E1; res_valid is high after E2.
  - Maximum throughput is one result per 2 cycles.
- proc_op_sel/proc_data_in hold their last issued values in IDLE/HOLD.
- Results are strictly in acceptance order; no data checking or arithmetic in this block. Division-by-zero or overflow results pass through as produced.
- Capacity: DEPTH commands in the FIFO plus one in the issue/result slot. With res_ready=0, DEPTH+1 commands are accepted before in_ready falls.
- Push on the same edge the FIFO is popped while full: push is rejected because in_ready was 0 before the edge. Push and pop on the same edge otherwise update count by net 0.
- Push into an empty FIFO is not visible to the FSM until the following cycle (no bypass).
- flush:
  - Empties the FIFO, clears res_valid, returns to IDLE and resets the index counter to 0.
  - Dominates a simultaneous push, pop or result handshake (all discarded).
- rst asserted mid-operation: immediate return to reset values; in-flight commands and results are lost.

Decomposition:
- Package op_proc_pkg:
  - opcode_e enum: OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - cmd_t struct {opcode_e opcode; logic [7:0] data; logic [IDX_W-1:0] index}; IDX_W default as a package constant.
  - issue_state_e enum {IDLE, DRIVE, HOLD}.
- Sub-module op_cmd_fifo: synchronous DEPTH-entry FIFO of cmd_t, with push/pop/full/empty/count/flush. The top holds the FSM, result register and index counter.

Test Plan:
- Reset: with res_ready=1, push ADD 8'h05, then assert rst during DRIVE -> all outputs 0, in_ready=1, no res_valid afterwards; next accepted command gets index 0.
- Single command: push ADD 8'h05 with res_ready=1 -> res_valid high exactly 2 cycles after accept, res_data=8'h0A, res_opcode=OP_ADD, res_index=0, res_valid low the next cycle.
- Mixed stream with res_ready=1: SUB 8'h37, MUL 8'h0F, MUL 8'h10 -> results 8'h00, 8'hE1, 8'h00 with indices 0, 1, 2, spaced 2 cycles apart.
- Backpressure (DEPTH=8): res_ready=0, offer 12 ADD commands data 1..12 -> exactly 9 accepted, in_ready=0, count=8. Raise res_ready -> results 2,4,...,18 with indices 0..8 in order; in_ready returns after the first pop.
- Flush: 5 commands queued, res_valid high, pulse flush with simultaneous in_valid -> count=0, res_valid=0, IDLE. The next command gets index 0 and yields the correct result.
- Index wrap (IDX_W=4): 17 sequential commands -> 16th result index 4'hF, 17th result index 4'h0.

Source files
------------

// File: rtl/op_issue_queue_pkg.sv
// Shared types for the op_issue_queue slice.
//   opcode_e      : processor operation encoding (ADD/SUB/MUL/DIV)
//   issue_state_e : issue FSM states
//   cmd_t         : buffered command {opcode, data, index}
// cmd_t carries IDX_W_DEF index bits; instances with a narrower IDX_W
// use the low IDX_W bits and leave the rest zero (IDX_W must not exceed
// IDX_W_DEF).
package op_proc_pkg;

  localparam int unsigned IDX_W_DEF = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    HOLD
  } issue_state_e;

  typedef struct packed {
    opcode_e                opcode;
    logic [7:0]             data;
    logic [IDX_W_DEF-1:0]   index;
  } cmd_t;

endpackage

// File: rtl/op_issue_queue_if.sv
// Command and result handshake bundle for op_issue_queue.
//   in_valid/in_ready/in_opcode/in_data          : command stream
//   res_valid/res_ready/res_data/res_opcode/res_index : result stream
// master = command producer / result consumer, slave = the queue.
interface op_issue_queue_if #(
  parameter int unsigned IDX_W = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_opcode;
  logic [7:0]       in_data;

  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic [1:0]       res_opcode;
  logic [IDX_W-1:0] res_index;

  modport master (
    output in_valid, in_opcode, in_data, res_ready,
    input  in_ready, res_valid, res_data, res_opcode, res_index
  );

  modport slave (
    input  in_valid, in_opcode, in_data, res_ready,
    output in_ready, res_valid, res_data, res_opcode, res_index
  );

endinterface

// File: rtl/op_issue_queue_cmd_fifo.sv
// op_cmd_fifo: DEPTH-entry synchronous FIFO of cmd_t.
//   clk, rst   : clock, asynchronous active-high reset
//   flush_i    : synchronous clear, dominates push/pop
//   push_i     : write din_i (ignored when full)
//   pop_i      : advance head (ignored when empty)
//   dout_o     : head entry
//   full_o, empty_o, count_o : occupancy status
module op_cmd_fifo
  import op_proc_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  cmd_t          din_i,
  output cmd_t          dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/op_issue_queue.sv
// op_issue_queue: buffers {opcode, data} commands, issues them one at a
// time to a combinational processor, and returns each captured result in
// acceptance order tagged with a sequence index.
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : synchronous clear of FIFO, result slot and index counter
//   bus (slave)   : command (in_*) and result (res_*) handshakes
//   proc_op_sel   : registered opcode driven to the processor
//   proc_data_in  : registered operand driven to the processor
//   proc_data_out : processor result, sampled one cycle after issue
//   count         : FIFO occupancy (excludes the command in the issue slot)
module op_issue_queue
  import op_proc_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  op_issue_queue_if.slave              bus,
  output logic [1:0]                   proc_op_sel,
  output logic [7:0]                   proc_data_in,
  input  logic [7:0]                   proc_data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  issue_state_e     state_q, state_d;
  opcode_e          proc_op_q, proc_op_d;
  logic [7:0]       proc_data_q, proc_data_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic             res_valid_q, res_valid_d;
  logic [7:0]       res_data_q, res_data_d;
  opcode_e          res_op_q, res_op_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  cmd_t push_cmd, head_cmd;

  op_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (push_cmd),
    .dout_o  (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign bus.in_ready   = !fifo_full;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_opcode = res_op_q;
  assign bus.res_index  = res_idx_q;
  assign proc_op_sel    = proc_op_q;
  assign proc_data_in   = proc_data_q;

  always_comb begin
    state_d     = state_q;
    proc_op_d   = proc_op_q;
    proc_data_d = proc_data_q;
    cur_idx_d   = cur_idx_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_idx_d   = res_idx_q;
    idx_d       = idx_q;
    fifo_pop    = 1'b0;

    push_cmd                   = '0;
    push_cmd.opcode            = opcode_e'(bus.in_opcode);
    push_cmd.data              = bus.in_data;
    push_cmd.index[IDX_W-1:0]  = idx_q;

    // in_ready reflects pre-edge fullness, so a push while full is dropped
    // even if the same edge pops.
    fifo_push = bus.in_valid && !fifo_full && !flush;
    if (fifo_push) idx_d = idx_q + 1'b1;

    if (flush) begin
      state_d     = IDLE;
      res_valid_d = 1'b0;
      idx_d       = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            proc_op_d   = head_cmd.opcode;
            proc_data_d = head_cmd.data;
            cur_idx_d   = head_cmd.index[IDX_W-1:0];
            state_d     = DRIVE;
          end
        end
        DRIVE: begin
          res_valid_d = 1'b1;
          res_data_d  = proc_data_out;
          res_op_d    = proc_op_q;
          res_idx_d   = cur_idx_q;
          state_d     = HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid_d = 1'b0;
            if (!fifo_empty) begin
              fifo_pop    = 1'b1;
              proc_op_d   = head_cmd.opcode;
              proc_data_d = head_cmd.data;
              cur_idx_d   = head_cmd.index[IDX_W-1:0];
              state_d     = DRIVE;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      proc_op_q   <= OP_ADD;
      proc_data_q <= '0;
      cur_idx_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= OP_ADD;
      res_idx_q   <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      proc_op_q   <= proc_op_d;
      proc_data_q <= proc_data_d;
      cur_idx_q   <= cur_idx_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_idx_q   <= res_idx_d;
      idx_q       <= idx_d;
    end
  end

endmodule

// File: tb/tb_op_issue_queue.sv
module tb_op_issue_queue;
  import op_proc_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [1:0]    proc_op_sel;
  logic [7:0]    proc_data_in;
  logic [7:0]    proc_data_out;
  logic [CW-1:0] count;

  op_issue_queue_if #(.IDX_W(IDX_W)) bus ();

  op_issue_queue #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .bus           (bus),
    .proc_op_sel   (proc_op_sel),
    .proc_data_in  (proc_data_in),
    .proc_data_out (proc_data_out),
    .count         (count)
  );

  always #5 clk = ~clk;

  // Processor stand-in: operand combined with itself.
  function automatic logic [7:0] proc_fn(input logic [1:0] op, input logic [7:0] d);
    logic [15:0] p;
    case (op)
      2'b00:   return d + d;
      2'b01:   return 8'h00;
      2'b10: begin
        p = {8'h00, d} * {8'h00, d};
        return p[7:0];
      end
      default: return (d == 8'h00) ? 8'hFF : 8'h01;
    endcase
  endfunction

  assign proc_data_out = proc_fn(proc_op_sel, proc_data_in);

  typedef struct {
    logic [1:0]       op;
    logic [7:0]       data;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t             exp_q[$];
  int unsigned      accepted;
  int               passed = 0;
  int               total  = 0;
  int               cyc    = 0;

  logic [7:0]       got_data[$];
  logic [IDX_W-1:0] got_idx[$];
  int               got_cyc[$];

  logic [1:0]       cmd_op[$];
  logic [7:0]       cmd_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic clear_model();
    exp_q.delete();
    accepted = 0;
  endtask

  task automatic clear_got();
    got_data.delete();
    got_idx.delete();
    got_cyc.delete();
  endtask

  // Observe handshakes pending at this edge, update the reference, advance.
  task automatic step();
    exp_t e;
    if (flush) begin
      clear_model();
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        got_data.push_back(bus.res_data);
        got_idx.push_back(bus.res_index);
        got_cyc.push_back(cyc);
        chk("res_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("res_data", 32'(bus.res_data), 32'(proc_fn(e.op, e.data)));
          chk("res_opcode", 32'(bus.res_opcode), 32'(e.op));
          chk("res_index", 32'(bus.res_index), 32'(e.idx));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.op   = bus.in_opcode;
        e.data = bus.in_data;
        e.idx  = IDX_W'(accepted % (2 ** IDX_W));
        accepted++;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Offer queued commands; optionally keep going until all results return.
  task automatic feed(input int max_cyc, input bit want_drain);
    bit acc;
    for (int c = 0; c < max_cyc; c++) begin
      if (cmd_op.size() == 0 && (!want_drain || exp_q.size() == 0)) break;
      bus.in_valid = (cmd_op.size() != 0);
      if (cmd_op.size() != 0) begin
        bus.in_opcode = cmd_op[0];
        bus.in_data   = cmd_data[0];
      end
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) begin
        void'(cmd_op.pop_front());
        void'(cmd_data.pop_front());
      end
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] mix_exp [3];
    logic [1:0] mix_op  [3];
    logic [7:0] mix_dat [3];
    int         n_acc;

    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 2'b00;
    bus.in_data   = 8'h00;
    bus.res_ready = 1'b0;
    clear_model();
    @(posedge clk);
    #1;

    // Reset values
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_res_opcode", 32'(bus.res_opcode), 32'd0);
    chk("rst_res_index", 32'(bus.res_index), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_proc_op", 32'(proc_op_sel), 32'd0);
    chk("rst_proc_data", 32'(proc_data_in), 32'd0);
    rst = 1'b0;

    // Reset asserted while a command is in DRIVE
    bus.res_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_opcode = OP_ADD;
    bus.in_data   = 8'h05;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("drive_proc_data", 32'(proc_data_in), 32'h05);
    chk("drive_proc_op", 32'(proc_op_sel), 32'(OP_ADD));
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_proc_data", 32'(proc_data_in), 32'd0);
    clear_model();
    clear_got();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_result", 32'(bus.res_valid), 32'd0);
    end

    // Single command latency
    clear_got();
    bus.in_valid  = 1'b1;
    bus.in_opcode = OP_ADD;
    bus.in_data   = 8'h05;
    step();
    bus.in_valid = 1'b0;
    chk("single_e0_valid", 32'(bus.res_valid), 32'd0);
    step();
    chk("single_e1_valid", 32'(bus.res_valid), 32'd0);
    step();
    chk("single_e2_valid", 32'(bus.res_valid), 32'd1);
    chk("single_data", 32'(bus.res_data), 32'h0A);
    chk("single_opcode", 32'(bus.res_opcode), 32'(OP_ADD));
    chk("single_index", 32'(bus.res_index), 32'd0);
    step();
    chk("single_after_valid", 32'(bus.res_valid), 32'd0);

    // Mixed stream
    pulse_flush();
    clear_got();
    mix_op  = '{OP_SUB, OP_MUL, OP_MUL};
    mix_dat = '{8'h37, 8'h0F, 8'h10};
    mix_exp = '{8'h00, 8'hE1, 8'h00};
    for (int i = 0; i < 3; i++) begin
      cmd_op.push_back(mix_op[i]);
      cmd_data.push_back(mix_dat[i]);
    end
    feed(40, 1'b1);
    chk("mix_n", 32'(got_data.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("mix_data", 32'(got_data[i]), 32'(mix_exp[i]));
      chk("mix_index", 32'(got_idx[i]), 32'(i));
    end
    chk("mix_gap01", 32'(got_cyc[1] - got_cyc[0]), 32'd2);
    chk("mix_gap12", 32'(got_cyc[2] - got_cyc[1]), 32'd2);

    // Backpressure: capacity is DEPTH + 1
    pulse_flush();
    clear_got();
    bus.res_ready = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cmd_op.push_back(OP_ADD);
      cmd_data.push_back(8'(i));
    end
    feed(16, 1'b0);
    n_acc = 12 - cmd_op.size();
    chk("bp_accepted", 32'(n_acc), 32'(DEPTH + 1));
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_count", 32'(count), 32'(DEPTH));
    chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
    cmd_op.delete();
    cmd_data.delete();
    bus.res_ready = 1'b1;
    step();
    chk("bp_ready_after_pop", 32'(bus.in_ready), 32'd1);
    feed(60, 1'b1);
    chk("bp_n", 32'(got_data.size()), 32'(DEPTH + 1));
    for (int i = 0; i <= DEPTH; i++) begin
      chk("bp_data", 32'(got_data[i]), 32'(2 * (i + 1)));
      chk("bp_index", 32'(got_idx[i]), 32'(i));
    end

    // Flush with a simultaneous push
    pulse_flush();
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_op.push_back(OP_SUB);
      cmd_data.push_back(8'(i + 3));
    end
    feed(12, 1'b0);
    chk("fl_pre_count", 32'(count), 32'd4);
    chk("fl_pre_valid", 32'(bus.res_valid), 32'd1);
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_opcode = OP_MUL;
    bus.in_data   = 8'h77;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_res_valid", 32'(bus.res_valid), 32'd0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("fl_idle", 32'(bus.res_valid), 32'd0);
    end
    bus.res_ready = 1'b1;
    clear_got();
    cmd_op.push_back(OP_ADD);
    cmd_data.push_back(8'h21);
    feed(20, 1'b1);
    chk("fl_next_n", 32'(got_data.size()), 32'd1);
    chk("fl_next_data", 32'(got_data[0]), 32'h42);
    chk("fl_next_index", 32'(got_idx[0]), 32'd0);

    // Index wrap at 2^IDX_W
    pulse_flush();
    clear_got();
    for (int i = 0; i < 17; i++) begin
      cmd_op.push_back(2'($urandom_range(0, 3)));
      cmd_data.push_back(8'($urandom_range(0, 255)));
    end
    feed(100, 1'b1);
    chk("wrap_n", 32'(got_idx.size()), 32'd17);
    chk("wrap_idx15", 32'(got_idx[15]), 32'hF);
    chk("wrap_idx16", 32'(got_idx[16]), 32'h0);

    // Random traffic against the reference queue
    pulse_flush();
    for (int i = 0; i < 400; i++) begin
      flush         = ($urandom_range(0, 63) == 0);
      bus.in_valid  = $urandom_range(0, 1) == 1;
      bus.in_opcode = 2'($urandom_range(0, 3));
      bus.in_data   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      bus.res_ready = $urandom_range(0, 3) != 0;
      chk("rnd_count_bound", 32'(count <= CW'(DEPTH)), 32'd1);
      chk("rnd_in_ready", 32'(bus.in_ready), 32'(count != CW'(DEPTH)));
      step();
    end
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
